// File: rtl/bus_master_if.sv
`timescale 1ns/1ps
// bus_master_if: turns one client word request into a single complete bus
// transaction (request, grant wait, one-cycle address strobe, ready wait,
// read-data capture). A ready timeout stops a dead or unmapped slave from
// hanging the client.
//
// Handshake: the client raises req while busy is low; the request is taken on
// that edge. Completion is the one-cycle done pulse, with err qualifying it
// (1 = timed out) and rd_data valid for reads. req is ignored while busy.
module bus_master_if #(
    parameter int TO_WIDTH = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        bus_req_,
    input  logic        bus_grnt_,
    output logic [29:0] bus_addr,
    output logic        bus_as_,
    output logic        bus_rw,
    output logic [31:0] bus_wr_data,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy_
);

    // Active-low bus levels and access-type encoding used across the codebase.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT);

    logic [1:0]          state;
    logic [TO_WIDTH-1:0] cnt;

    // busy is the only decoded output; everything else comes from flops.
    always_comb begin
        busy = (state != IDLE);
    end

    // Transaction sequencer: state, bus control strobes and completion status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bus_req_ <= DISABLE_;
            bus_as_  <= DISABLE_;
            done     <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        bus_req_ <= ENABLE_;
                        cnt      <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus_grnt_ == ENABLE_) begin
                        bus_as_ <= ENABLE_;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobe lasts exactly one cycle; grant is not watched here.
                    bus_as_ <= DISABLE_;
                    // Ready is tested first so a ready landing on the timeout
                    // cycle still completes normally.
                    if (bus_rdy_ == ENABLE_) begin
                        done     <= 1'b1;
                        err      <= 1'b0;
                        bus_req_ <= DISABLE_;
                        state    <= IDLE;
                    end else if (cnt == TO_LIMIT) begin
                        done     <= 1'b1;
                        err      <= 1'b1;
                        bus_req_ <= DISABLE_;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request latch: address, direction and write data held for the whole
    // transaction so the bus sees stable values until done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr    <= '0;
            bus_rw      <= READ;
            bus_wr_data <= '0;
        end else if (state == IDLE && req) begin
            bus_addr    <= addr;
            bus_rw      <= rw;
            bus_wr_data <= wr_data;
        end
    end

    // Read-data capture on a ready-terminated read; writes and timeouts keep
    // the previous value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (state == ACCESS && bus_rdy_ == ENABLE_ && bus_rw == READ) begin
            rd_data <= bus_rd_data;
        end
    end

endmodule
